// File: rtl/dec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dec_pkg                                                   |
// | Desc   : Shared constants and the reference one-hot decode function |
// |          for the dec binary-to-one-hot decoder.                    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package dec_pkg;

  localparam int DEC_IN_W_DEFAULT = 2;
  // Widest select code supported; the decode helper is sized for this.
  localparam int DEC_MAX_IN_W     = 6;
  localparam int DEC_MAX_OUT_W    = 1 << DEC_MAX_IN_W;

  // Full-width active-high decode; callers zero-extend the code and keep
  // only the low 2**IN_W bits, which always contain the selected bit.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
    input logic [DEC_MAX_IN_W-1:0] code,
    input logic                    en
  );
    logic [DEC_MAX_OUT_W-1:0] v;
    v = '0;
    if (en) v[code] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dec_core                                                  |
// | Desc   : Combinational binary-to-one-hot decode with optional      |
// |          output polarity inversion.                                |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dec_core
  import dec_pkg::*;
#(
  parameter int  IN_W    = DEC_IN_W_DEFAULT,
  parameter bit  ACT_LOW = 1'b0,
  localparam int OUT_W   = 2**IN_W
) (
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] out
);

  logic [DEC_MAX_IN_W-1:0]  w_code;
  logic [DEC_MAX_OUT_W-1:0] w_dec_full;

  // Decode the zero-extended code, then apply the requested polarity.
  always_comb begin
    w_code     = DEC_MAX_IN_W'(in);
    w_dec_full = onehot_decode(w_code, en);
    out        = ACT_LOW ? ~w_dec_full[OUT_W-1:0] : w_dec_full[OUT_W-1:0];
  end

  // Bits above OUT_W can never be selected; fold them into a sink.
  if (OUT_W < DEC_MAX_OUT_W) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = |w_dec_full[DEC_MAX_OUT_W-1:OUT_W];
  end

endmodule
`default_nettype wire

// File: rtl/dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dec                                                       |
// | Desc   : Parameterised binary-to-one-hot decoder with enable,      |
// |          optional output register and optional active-low output. |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dec
  import dec_pkg::*;
#(
  parameter int  IN_W    = DEC_IN_W_DEFAULT,  // legal range 1..6
  parameter bit  OUT_REG = 1'b1,
  parameter bit  ACT_LOW = 1'b0,
  localparam int OUT_W   = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  // Value shown while disabled or in reset: nothing selected.
  localparam logic [OUT_W-1:0] c_idle = {OUT_W{ACT_LOW}};

  logic [OUT_W-1:0] w_next;

  dec_core #(
    .IN_W    (IN_W),
    .ACT_LOW (ACT_LOW)
  ) u_core (
    .in  (in),
    .en  (en),
    .out (w_next)
  );

  if (OUT_REG) begin : g_reg
    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    // Capture the decode every edge; reset clears to the idle pattern.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out   <= c_idle;
        r_valid <= 1'b0;
      end else begin
        r_out   <= w_next;
        r_valid <= en;
      end
    end

    assign out       = r_out;
    assign out_valid = r_valid;

    // A valid registered result must have exactly one lane selected.
    always @(posedge clk) begin
      if (rst_n && r_valid) begin
        assert ($onehot(ACT_LOW ? ~r_out : r_out));
      end
    end
  end else begin : g_comb
    assign out       = w_next;
    assign out_valid = en;
  end

  // An unknown select while enabled would silently corrupt the one-hot.
  always_comb begin
    if (rst_n && en) begin
      assert (!$isunknown(in));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_dec                                                    |
// | Desc   : Self-checking bench for dec: default, combinational,      |
// |          active-low and 3-bit variants driven in lockstep.         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_dec;

  logic       clk;
  logic       rst_n;
  logic [1:0] in;
  logic       en;
  logic [2:0] in3;

  logic [3:0] out_m, out_c, out_l;
  logic       val_m, val_c, val_l;
  logic [7:0] out_3;
  logic       val_3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] main;
    logic       valid;
    logic [3:0] low;
    logic [7:0] w3;
  } exp_t;

  typedef struct {
    logic [1:0] code;
    logic       en;
    logic [3:0] exp_out;
    logic       exp_valid;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];

  dec u_main (.clk(clk), .rst_n(rst_n), .in(in), .en(en), .out(out_m), .out_valid(val_m));
  dec #(.OUT_REG(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .in(in), .en(en), .out(out_c), .out_valid(val_c));
  dec #(.ACT_LOW(1'b1)) u_low (.clk(clk), .rst_n(rst_n), .in(in), .en(en), .out(out_l), .out_valid(val_l));
  dec #(.IN_W(3)) u_w3 (.clk(clk), .rst_n(rst_n), .in(in3), .en(en), .out(out_3), .out_valid(val_3));

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " main out"}, 64'(out_m), 64'h0);
    chk({tag, " main valid"}, 64'(val_m), 64'h0);
    chk({tag, " low out"}, 64'(out_l), 64'hf);
    chk({tag, " low valid"}, 64'(val_l), 64'h0);
    chk({tag, " w3 out"}, 64'(out_3), 64'h0);
  endtask

  // Expected registered results for the current inputs
  task automatic push_exp(input logic [3:0] m, input logic v, input logic [2:0] c3);
    exp_t e;
    e.main  = m;
    e.valid = v;
    e.low   = ~m;
    e.w3    = v ? (8'd1 << c3) : 8'd0;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty required entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " main out"}, 64'(out_m), 64'(e.main));
      chk({tag, " main valid"}, 64'(val_m), 64'(e.valid));
      chk({tag, " low out"}, 64'(out_l), 64'(e.low));
      chk({tag, " low valid"}, 64'(val_l), 64'(e.valid));
      chk({tag, " w3 out"}, 64'(out_3), 64'(e.w3));
      chk({tag, " w3 valid"}, 64'(val_3), 64'(e.valid));
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{2'b01, 1'b1, 4'b0010, 1'b1};
    tbl[3]  = '{2'b11, 1'b1, 4'b1000, 1'b1};
    tbl[4]  = '{2'b00, 1'b1, 4'b0001, 1'b1};
    tbl[5]  = '{2'b01, 1'b1, 4'b0010, 1'b1};
    tbl[6]  = '{2'b10, 1'b1, 4'b0100, 1'b1};
    tbl[7]  = '{2'b11, 1'b1, 4'b1000, 1'b1};
    tbl[8]  = '{2'b10, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{2'b11, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{2'b10, 1'b1, 4'b0100, 1'b1};

    // Reset asserted with an enabled code present: outputs idle at once
    rst_n = 1'b1;
    in    = 2'b11;
    en    = 1'b1;
    in3   = 3'b000;
    #1 rst_n = 1'b0;
    #1 chk_reset("reset immediate");
    @(posedge clk); #1;
    chk_reset("reset held");
    #2 rst_n = 1'b1;
    push_exp(4'b1000, 1'b1, in3);
    @(posedge clk); #1;
    pop_check("first after reset");

    // Table sweep; the 3-bit variant sees {1, code}
    for (int i = 0; i < 11; i++) begin
      in  = tbl[i].code;
      en  = tbl[i].en;
      in3 = {1'b1, tbl[i].code};
      push_exp(tbl[i].exp_out, tbl[i].exp_valid, in3);
      #1;
      chk($sformatf("vec%0d comb out", i), 64'(out_c), 64'(tbl[i].exp_out));
      chk($sformatf("vec%0d comb valid", i), 64'(val_c), 64'(tbl[i].exp_valid));
      @(posedge clk); #1;
      pop_check($sformatf("vec%0d", i));
    end

    // Mid-stream reset pulse between edges discards the pending decode
    in  = 2'b10;
    en  = 1'b1;
    in3 = 3'b110;
    push_exp(4'b0100, 1'b1, in3);
    #2 rst_n = 1'b0;
    #1 chk_reset("midstream reset");
    sb.delete();
    #1 rst_n = 1'b1;
    push_exp(4'b0100, 1'b1, in3);
    @(posedge clk); #1;
    pop_check("after midstream reset");

    // Disable following enable returns every variant to idle
    en = 1'b0;
    push_exp(4'b0000, 1'b0, in3);
    @(posedge clk); #1;
    pop_check("disable");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec.md
Name: dec

Overview:
- Parameterised binary-to-one-hot decoder with active-high enable; default is 2-to-4.
- Output is registered: one clock of latency, asynchronously cleared by reset.
- Used wherever a small select field must drive per-lane enables, for example register-bank write strobes or mux selects in the subtractor datapath.
- A combinational bypass is selectable by parameter.

Parameters:
- IN_W, 2, width of the binary select input; legal range 1..6.
- OUT_W, 2**IN_W, width of the one-hot output; derived, must not be overridden independently.
- OUT_REG, 1:
  - 1: output registered (latency 1 clk).
  - 0: output purely combinational (clk/rst_n unused).
- ACT_LOW, 0:
  - 0: selected bit = 1, others = 0.
  - 1: output inverted, selected bit = 0, others = 1; disabled/reset value is all ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  IN_W  binary select code.
- en  input  1  decode enable, active high.
- out  output  OUT_W  one-hot decoded result (polarity per ACT_LOW).
- out_valid  output  1  high when out currently reflects an enabled decode.

Behaviour:
- Interface timing (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Decode function, with ACT_LOW=0:
  - next_out[i] = en && (in == i), for i in 0..OUT_W-1.
  - Exactly one bit is set when en=1; all bits are 0 when en=0.
  - ACT_LOW=1 applies a bitwise inversion after decode.
- OUT_REG=1:
  - out and out_valid are flops updated on every rising clk edge from the current in/en.
  - Latency is exactly 1 cycle; there is no hold or stall; a new code is accepted every cycle.
- OUT_REG=0:
  - out = next_out and out_valid = en, combinationally.
  - No flops are inferred.
- Reset:
  - rst_n low immediately forces out to all zeros (all ones if ACT_LOW=1) and out_valid to 0, independent of clk.
  - While rst_n is low, in/en are ignored.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
  - Reset asserted mid-stream discards the pending decode; there is no recovery of the prior value.
- en=0 with any in value: the result is the disabled value (zeros / ones); in is don't-care.
- Changing in while en stays 1 switches the one-hot bit on the next edge. No cycle has zero or two bits active when sampled at clock edges.
- X/undefined in with en=1: the output must not be one-hot-corrupted silently.
  - A simulation-only assertion flags it.
  - Synthesis treats it as don't-care.
- Invariant, checked by assertion when OUT_REG=1 and out_valid=1: $onehot(out) (or $onehot(~out) if ACT_LOW).

Decomposition:
- Package dec_pkg:
  - Constant DEC_IN_W_DEFAULT=2.
  - Function onehot_decode(code, en) returning the OUT_W vector; used by both RTL and bench models.
- One sub-module, dec_core: pure combinational decode plus polarity inversion, parameterised by IN_W and ACT_LOW.
- Top dec wraps dec_core with the optional output register stage (generate on OUT_REG) and the assertions.

Test Plan:
- Reset: assert rst_n=0 with in=11, en=1 -> out=0000 and out_valid=0 immediately; after release, next edge gives out=1000 and out_valid=1.
- Disabled: in=00, en=0, then in=01, en=0 -> out=0000 and out_valid=0 on each following edge.
- Enabled decode: in=01, en=1 -> out=0010 one cycle later; then in=11, en=1 -> out=1000 on the next edge.
- Exhaustive sweep: all 4 codes with en=1 each cycle -> out=0001, 0010, 0100, 1000 with 1-cycle lag; onehot assertion never fires.
- Mid-stream reset: drive in=10, en=1; pulse rst_n low between edges -> out drops to 0000 asynchronously; next edge after release gives 0100.
- Variants:
  - OUT_REG=0: in=10, en=1 -> out=0100 with zero latency.
  - ACT_LOW=1: in=10, en=1 -> out=1011; en=0 -> out=1111.
  - IN_W=3: in=101, en=1 -> out=00100000.
